// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } ArbState_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - rotating priority pick of the first request at or after start
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    rot = N'({req, req} >> start);
    any = 1'b0;
    off = '0;
    // Descending scan so the lowest rotated position wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        off = IW'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= N_W) begin
      sum = sum - N_W;
    end
    idx = sum[IW-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - credit-gated round-robin burst arbiter for a FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 128,
  parameter int BURST   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           IN_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     IN_data,
  output logic [NUM_REQ-1:0]           OUT_ready,
  input  logic                         IN_pop,
  output logic                         OUT_valid,
  output logic [WIDTH-1:0]             OUT_data,
  output logic [$clog2(NUM_REQ)-1:0]   OUT_id,
  output logic [$clog2(DEPTH+1)-1:0]   OUT_credits
);

  localparam int IW = clog2_min1(NUM_REQ);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [BW-1:0] BMAX     = BW'(BURST);
  localparam ArbState_t     PICK_NEXT = (BURST > 1) ? LOCKED : IDLE;

  ArbState_t     state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0] out_id_q, out_id_d;

  logic [IW-1:0]      start;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic               accept;
  logic [IW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] grant_vec;

  assign start = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (IN_valid),
    .start (start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant decision; IN_pop deliberately does not enter this path.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    grant_idx = owner_q;
    grant_vec = '0;
    if (!rst && credits_q != '0) begin
      if (state_q == LOCKED && IN_valid[owner_q] && cnt_q < BMAX) begin
        accept    = 1'b1;
        grant_idx = owner_q;
        grant_vec = NUM_REQ'(1) << owner_q;
        cnt_d     = cnt_q + 1'b1;
      end else if (pick_any) begin
        accept    = 1'b1;
        grant_idx = pick_idx;
        grant_vec = pick_gnt;
        owner_d   = pick_idx;
        last_d    = pick_idx;
        cnt_d     = BW'(1);
        state_d   = PICK_NEXT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign OUT_ready = grant_vec;

  always_comb begin
    credits_d = credits_q;
    case ({accept, IN_pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = (credits_q == FULL) ? credits_q : credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    out_valid_d = accept;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (accept) begin
      out_data_d = IN_data[grant_idx*WIDTH +: WIDTH];
      out_id_d   = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= LAST_IDX;
      cnt_q       <= '0;
      credits_q   <= FULL;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      credits_q   <= credits_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign OUT_valid   = out_valid_q;
  assign OUT_data    = out_data_q;
  assign OUT_id      = out_id_q;
  assign OUT_credits = credits_q;

  // A pop into a full-credit count with no accept means the FIFO popped an entry it never held.
  pop_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(IN_pop && !accept && credits_q == FULL));

  grant_onehot_a: assert property (@(posedge clk) $onehot0(OUT_ready));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 128;
  localparam int B = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     in_valid = '0;
  logic [N*W-1:0]   in_data = '0;
  logic             in_pop = 1'b0;
  logic [N-1:0]     out_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [1:0]       out_id;
  logic [7:0]       out_credits;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .DEPTH   (D),
    .BURST   (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .IN_valid    (in_valid),
    .IN_data     (in_data),
    .OUT_ready   (out_ready),
    .IN_pop      (in_pop),
    .OUT_valid   (out_valid),
    .OUT_data    (out_data),
    .OUT_id      (out_id),
    .OUT_credits (out_credits)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         m_owner = -1;
  int         m_cnt = 0;
  int         m_last = N - 1;
  int         m_credits = D;
  bit         m_ovalid = 1'b0;
  logic [W-1:0] m_odata = '0;
  int         m_oid = 0;

  function automatic int model_pick();
    if (rst || m_credits == 0) return -1;
    if (m_owner >= 0 && in_valid[m_owner] && m_cnt < B) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (in_valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] one;
    one = 1;
    return (g < 0) ? '0 : (one << g);
  endfunction

  task automatic tick(output int g);
    logic [W-1:0] d;
    bit cont;
    g = model_pick();
    d = (g >= 0) ? in_data[g*W +: W] : '0;
    cont = (g >= 0 && g == m_owner && m_cnt < B);
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_last = N - 1; m_credits = D;
      m_ovalid = 1'b0; m_odata = '0; m_oid = 0;
    end else begin
      if (g >= 0) begin
        m_ovalid = 1'b1; m_odata = d; m_oid = g;
        if (cont) m_cnt++;
        else begin m_owner = g; m_last = g; m_cnt = 1; end
      end else begin
        m_ovalid = 1'b0;
        if (m_credits != 0) m_owner = -1;
      end
      m_credits = m_credits - ((g >= 0) ? 1 : 0) + (in_pop ? 1 : 0);
      if (m_credits > D) m_credits = D;
    end
    #1;
  endtask

  task automatic pulse_reset();
    int g;
    rst = 1'b1; in_valid = '0; in_pop = 1'b0;
    tick(g);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int g;
    rst = 1'b1; in_valid = '1; in_pop = 1'b0;
    #1;
    n_checks++;
    if (out_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", out_ready); end
    tick(g);
    tick(g);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    n_checks++;
    if (out_data !== '0 || out_id !== '0) begin n_fail++; $display("FAIL reset_data got=%h/%0d want=0/0", out_data, out_id); end
    n_checks++;
    if (out_credits !== 8'(D)) begin n_fail++; $display("FAIL reset_credits got=%0d want=%0d", out_credits, D); end
    rst = 1'b0; in_valid = '0;
  endtask

  task automatic test_single();
    int g;
    pulse_reset();
    in_valid = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      in_data[2*W +: W] = 32'(i);
      #1;
      n_checks++;
      if (out_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready[%0d] got=%b want=0100", i, out_ready); end
      tick(g);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || out_id !== 2'd2) begin
        n_fail++; $display("FAIL single_write[%0d] got=%b/%0d/%0d want=1/%0d/2", i, out_valid, out_data, out_id, i);
      end
    end
    in_valid = '0;
    #1;
    n_checks++;
    if (out_ready !== '0) begin n_fail++; $display("FAIL single_idle_ready got=%b want=0", out_ready); end
    tick(g);
    n_checks++;
    if (out_valid !== 1'b0 || out_credits !== 8'd118) begin
      n_fail++; $display("FAIL single_end got=%b/%0d want=0/118", out_valid, out_credits);
    end
  endtask

  task automatic test_fairness();
    int g;
    int want;
    pulse_reset();
    for (int r = 0; r < N; r++) in_data[r*W +: W] = 32'h1000 * r;
    in_valid = '1; in_pop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      want = (i / 4) % 4;
      #1;
      n_checks++;
      if (out_ready !== oh(want)) begin n_fail++; $display("FAIL fair_ready[%0d] got=%b want=%b", i, out_ready, oh(want)); end
      tick(g);
      n_checks++;
      if (out_valid !== 1'b1 || out_id !== 2'(want) || out_data !== 32'h1000 * want) begin
        n_fail++; $display("FAIL fair_write[%0d] got=%b/%0d want=1/%0d", i, out_valid, out_id, want);
      end
    end
    in_valid = '0; in_pop = 1'b0;
    n_checks++;
    if (out_credits !== 8'(D)) begin n_fail++; $display("FAIL fair_credits got=%0d want=%0d", out_credits, D); end
  endtask

  task automatic test_early_release();
    int g;
    logic [N-1:0] vtab [4] = '{4'b1010, 4'b1010, 4'b1000, 4'b0111};
    logic [N-1:0] rtab [4] = '{4'b0010, 4'b0010, 4'b1000, 4'b0001};
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = vtab[i];
      #1;
      n_checks++;
      if (out_ready !== rtab[i]) begin n_fail++; $display("FAIL early_ready[%0d] got=%b want=%b", i, out_ready, rtab[i]); end
      tick(g);
    end
    in_valid = '0;
    n_checks++;
    if (out_id !== 2'd0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL early_last_id got=%0d want=0", out_id); end
  endtask

  task automatic test_credit_exhaust();
    int g;
    pulse_reset();
    in_valid = 4'b0001;
    for (int i = 0; i < D; i++) begin
      in_data[0 +: W] = 32'(i);
      #1;
      n_checks++;
      if (out_ready !== 4'b0001) begin n_fail++; $display("FAIL exh_ready[%0d] got=%b want=0001", i, out_ready); end
      tick(g);
    end
    n_checks++;
    if (out_credits !== 8'd0) begin n_fail++; $display("FAIL exh_zero got=%0d want=0", out_credits); end
    n_checks++;
    if (out_ready !== '0) begin n_fail++; $display("FAIL exh_blocked got=%b want=0", out_ready); end
    tick(g);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL exh_novalid got=%b want=0", out_valid); end
    in_pop = 1'b1;
    #1;
    n_checks++;
    if (out_ready !== '0) begin n_fail++; $display("FAIL exh_pop_same_cycle got=%b want=0", out_ready); end
    tick(g);
    in_pop = 1'b0;
    n_checks++;
    if (out_credits !== 8'd1) begin n_fail++; $display("FAIL exh_pop_credit got=%0d want=1", out_credits); end
    #1;
    n_checks++;
    if (out_ready !== 4'b0001) begin n_fail++; $display("FAIL exh_regrant got=%b want=0001", out_ready); end
    tick(g);
    n_checks++;
    if (out_valid !== 1'b1 || out_credits !== 8'd0) begin
      n_fail++; $display("FAIL exh_one_accept got=%b/%0d want=1/0", out_valid, out_credits);
    end
    in_pop = 1'b1;
    tick(g);
    n_checks++;
    if (out_valid !== 1'b0 || out_credits !== 8'd1) begin
      n_fail++; $display("FAIL exh_refill got=%b/%0d want=0/1", out_valid, out_credits);
    end
    #1;
    n_checks++;
    if (out_ready !== 4'b0001) begin n_fail++; $display("FAIL exh_pop_accept_ready got=%b want=0001", out_ready); end
    tick(g);
    n_checks++;
    if (out_valid !== 1'b1 || out_credits !== 8'd1) begin
      n_fail++; $display("FAIL exh_pop_accept got=%b/%0d want=1/1", out_valid, out_credits);
    end
    in_pop = 1'b0; in_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    int g;
    logic [N-1:0] want;
    pulse_reset();
    in_valid = 4'b0001;
    tick(g);
    tick(g);
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_ready !== '0) begin n_fail++; $display("FAIL midrst_ready got=%b want=0", out_ready); end
    tick(g);
    n_checks++;
    if (out_valid !== 1'b0 || out_credits !== 8'(D)) begin
      n_fail++; $display("FAIL midrst_state got=%b/%0d want=0/%0d", out_valid, out_credits, D);
    end
    rst = 1'b0;
    in_valid = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      want = (i < 4) ? 4'b0001 : 4'b0010;
      #1;
      n_checks++;
      if (out_ready !== want) begin n_fail++; $display("FAIL midrst_burst[%0d] got=%b want=%b", i, out_ready, want); end
      tick(g);
    end
    in_valid = '0;
  endtask

  task automatic test_random();
    int g;
    pulse_reset();
    for (int r = 0; r < N; r++) begin
      in_data[r*W +: W] = $urandom;
      in_valid[r] = ($urandom_range(0, 1) == 1);
    end
    for (int c = 0; c < 400; c++) begin
      #1;
      n_checks++;
      if (out_ready !== oh(model_pick())) begin
        n_fail++; $display("FAIL rand_ready[%0d] got=%b want=%b", c, out_ready, oh(model_pick()));
      end
      tick(g);
      n_checks++;
      if (out_valid !== m_ovalid || out_credits !== 8'(m_credits)) begin
        n_fail++; $display("FAIL rand_regs[%0d] got=%b/%0d want=%b/%0d", c, out_valid, out_credits, m_ovalid, m_credits);
      end
      if (m_ovalid) begin
        n_checks++;
        if (out_data !== m_odata || out_id !== 2'(m_oid)) begin
          n_fail++; $display("FAIL rand_data[%0d] got=%h/%0d want=%h/%0d", c, out_data, out_id, m_odata, m_oid);
        end
      end
      for (int r = 0; r < N; r++) begin
        if (g == r) begin
          in_data[r*W +: W] = $urandom;
          in_valid[r] = ($urandom_range(0, 3) != 0);
        end else if (!in_valid[r]) begin
          in_valid[r] = ($urandom_range(0, 2) == 0);
        end
      end
      in_pop = (m_credits < D) && ($urandom_range(0, 9) < 6);
    end
    in_valid = '0; in_pop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_early_release();
    test_credit_exhaust();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
